// File: rtl/score_bcd_counter.sv
// Three-digit BCD score counter (000-999). Adds drain one point per cycle; corrections subtract one point.
// Every output comes straight from a register.
module score_bcd_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       add_valid,
  input  logic [1:0] add_pts,
  input  logic       sub_one,
  output logic       busy,
  output logic       sat,
  output logic [3:0] bcd_units,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_hund
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e     state_q;
  logic [1:0] pend_q;
  logic [3:0] units_q, tens_q, hund_q;
  logic       busy_q, sat_q;

  logic       at_max, at_min;
  logic [3:0] units_inc_d, tens_inc_d, hund_inc_d;
  logic [3:0] units_dec_d, tens_dec_d, hund_dec_d;

  // Carry and borrow chains. These are only consumed when the score is not at
  // 999 (increment) or 000 (decrement), so the hundreds digit never wraps.
  always_comb begin
    at_max      = (hund_q == 4'd9) && (tens_q == 4'd9) && (units_q == 4'd9);
    at_min      = (hund_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd0);

    units_inc_d = (units_q == 4'd9) ? 4'd0 : units_q + 4'd1;
    tens_inc_d  = tens_q;
    hund_inc_d  = hund_q;
    if (units_q == 4'd9) begin
      tens_inc_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      if (tens_q == 4'd9) hund_inc_d = hund_q + 4'd1;
    end

    units_dec_d = (units_q == 4'd0) ? 4'd9 : units_q - 4'd1;
    tens_dec_d  = tens_q;
    hund_dec_d  = hund_q;
    if (units_q == 4'd0) begin
      tens_dec_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
      if (tens_q == 4'd0) hund_dec_d = hund_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 2'd0;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      pend_q  <= 2'd0;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (add_valid && (add_pts != 2'b00)) begin
            pend_q  <= add_pts;
            state_q <= COUNT;
            busy_q  <= 1'b1;
          end else if (sub_one && !at_min) begin
            units_q <= units_dec_d;
            tens_q  <= tens_dec_d;
            hund_q  <= hund_dec_d;
          end
        end
        COUNT: begin
          // Pending keeps draining at 999 so busy timing is unaffected by saturation.
          if (at_max) begin
            sat_q <= 1'b1;
          end else begin
            units_q <= units_inc_d;
            tens_q  <= tens_inc_d;
            hund_q  <= hund_inc_d;
          end
          pend_q <= pend_q - 2'd1;
          if (pend_q == 2'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign sat       = sat_q;
  assign bcd_units = units_q;
  assign bcd_tens  = tens_q;
  assign bcd_hund  = hund_q;

endmodule

// File: doc/score_bcd_counter.md
SCORE_BCD_COUNTER -- requirements
Module: score_bcd_counter

Interface
REQ-001 Parameters: none; score range fixed at 000-999 BCD.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 clear  input  1  synchronous score clear, active-high.
REQ-005 add_valid  input  1  add-request strobe, sampled each cycle.
REQ-006 add_pts  input  2  points for the add request: 01=1, 10=2, 11=3, 00=no-op.
REQ-007 sub_one  input  1  correction strobe, subtracts 1 point.
REQ-008 busy  output  1  high while an add is in progress.
REQ-009 sat  output  1  sticky saturation flag, high once any increment is blocked at 999.
REQ-010 bcd_units  output  4  units digit, BCD 0-9, feeds the 7-segment decoder.
REQ-011 bcd_tens  output  4  tens digit, BCD 0-9, feeds the 7-segment decoder.
REQ-012 bcd_hund  output  4  hundreds digit, BCD 0-9, feeds the 7-segment decoder.

Function
REQ-013 All outputs SHALL be driven directly from registers, with no combinational input-to-output path.
REQ-014 The FSM SHALL have exactly two states, IDLE and COUNT, plus a 2-bit pending-points register.
REQ-015 In IDLE with add_valid=1 and add_pts!=00, the block SHALL load pending=add_pts, enter COUNT and assert busy on the next edge.
REQ-016 In IDLE with add_valid=1 and add_pts=00, the block SHALL take no action.
REQ-017 In COUNT, each cycle SHALL increment the score by exactly 1 and decrement pending by 1.
REQ-018 On the increment that takes pending to 0, the block SHALL return to IDLE and deassert busy.
REQ-019 Adding N points SHALL keep busy high for exactly N cycles, and the final score SHALL be visible on the edge that deasserts busy.
REQ-020 Increment carry SHALL be: units 9->0 with carry into tens; tens 9->0 with carry into hundreds.
REQ-021 No digit SHALL ever hold a value above 9.
REQ-022 An increment at 999 SHALL leave the score at 999 and set sat=1, while pending continues to drain normally.
REQ-023 In IDLE, sub_one=1 SHALL decrement the score by 1 in a single cycle, with borrow rules mirroring REQ-020 (units 0->9 borrows from tens, and so on).
REQ-024 sub_one at 000 SHALL leave the score at 000, and this SHALL NOT be flagged.
REQ-025 In IDLE, same-cycle priority SHALL be clear > add > sub_one; a lower-priority request in the same cycle SHALL be dropped, not queued.
REQ-026 In COUNT, add_valid and sub_one SHALL be ignored and dropped.
REQ-027 clear=1 in any state SHALL, on the next edge, set all digits to 0, pending to 0 and sat to 0, and move the FSM to IDLE, aborting any add in progress.
REQ-028 sat SHALL remain high until clear or reset.

Reset
REQ-029 While reset=1, the block SHALL hold bcd_hund/bcd_tens/bcd_units=0/0/0, busy=0, sat=0, pending=0 and state IDLE, independent of clk.
REQ-030 reset asserted mid-COUNT SHALL abort the add immediately and produce no partial further increments.
REQ-031 After reset deasserts, the first active edge SHALL accept requests normally.

Verification
REQ-032 The bench SHALL cover: reset, then add_pts=11 pulsed once -> busy high for 3 cycles, score 001, 002, 003, then busy=0 with score 003.
REQ-033 The bench SHALL cover: score 098, add 2 -> 099, then 100 (double carry); sat=0.
REQ-034 The bench SHALL cover: score 998, add 3 -> 999, 999, 999; sat=1 and busy drops after 3 cycles; sub_one -> 998 with sat still 1.
REQ-035 The bench SHALL cover: score 000, sub_one -> 000; then score 100, sub_one -> 099.
REQ-036 The bench SHALL cover: during COUNT, pulse add_valid and sub_one -> both ignored; clear during COUNT -> 000, busy=0, sat=0 on the next edge.
REQ-037 The bench SHALL cover: reset asserted asynchronously between edges during COUNT -> outputs zero before the next clk edge.
